// File: rtl/pixel_stream_packer.sv
// Packs 8-bit RGB pixels into 32-bit AXI4-Stream video words through a small FWFT FIFO,
// and checks line/frame geometry of the accepted input beats against the configured size.
module pixel_stream_packer #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] ALPHA = 8'hFF
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [12:0]               image_width,
    input  logic [12:0]               image_height,
    input  logic [7:0]                in_r,
    input  logic [7:0]                in_g,
    input  logic [7:0]                in_b,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic                      in_eol,
    output logic                      in_ready,
    output logic [31:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tuser,
    output logic                      m_axis_tlast,
    input  logic                      err_clear,
    output logic                      line_err,
    output logic                      sof_err,
    output logic                      frame_done,
    output logic [15:0]               frame_count,
    output logic [$clog2(DEPTH):0]    fill_level
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [25:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          in_ready_r;
    logic          tvalid_r;
    logic          acc_s;
    logic          rd_s;
    logic [25:0]   head_s;

    logic [12:0]   x_cnt_r;
    logic [12:0]   y_cnt_r;
    logic          armed_r;
    logic          line_err_r;
    logic          sof_err_r;
    logic          frame_done_r;
    logic [15:0]   frame_count_r;

    logic [12:0]   x_s;
    logic [12:0]   y_s;
    logic [12:0]   x_nxt_s;
    logic [12:0]   y_nxt_s;
    logic [12:0]   w_last_s;
    logic [12:0]   h_last_s;
    logic          armed_s;
    logic          line_bad_s;
    logic          sof_bad_s;
    logic          frame_end_s;

    assign acc_s  = in_valid & in_ready_r;
    assign rd_s   = tvalid_r & m_axis_tready;
    assign head_s = mem_r[rd_ptr_r];

    // Next occupancy from the accept/read pair
    always_comb begin
        count_nxt_s = count_r;
        case ({acc_s, rd_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; entries are don't-care until written
    always_ff @(posedge aclk) begin
        if (acc_s) begin
            mem_r[wr_ptr_r] <= {in_sof, in_eol, in_r, in_g, in_b};
        end
    end

    // Pointers, occupancy and the registered handshake flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            tvalid_r   <= 1'b0;
        end else begin
            if (acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r    <= count_nxt_s;
            // Ready comes from next occupancy, so it rises one cycle after release or a read
            in_ready_r <= (count_nxt_s < DEPTH_C);
            tvalid_r   <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Position of the current beat and the checks made on it
    always_comb begin
        w_last_s = image_width - 13'd1;
        h_last_s = image_height - 13'd1;
        if (in_sof) begin
            x_s = 13'd0;
            y_s = 13'd0;
        end else begin
            x_s = x_cnt_r;
            y_s = y_cnt_r;
        end
        // The checker stays quiet until the first SOF arms it
        armed_s     = armed_r | in_sof;
        sof_bad_s   = armed_r & in_sof & ((x_cnt_r != 13'd0) | (y_cnt_r != 13'd0));
        line_bad_s  = armed_s & (in_eol ? (x_s != w_last_s) : (x_s == w_last_s));
        frame_end_s = armed_s & in_eol & (y_s == h_last_s);
        if (in_eol) begin
            x_nxt_s = 13'd0;
            y_nxt_s = (y_s == h_last_s) ? 13'd0 : (y_s + 13'd1);
        end else begin
            x_nxt_s = x_s + 13'd1;
            y_nxt_s = y_s;
        end
    end

    // Geometry counters, sticky errors and frame statistics
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_cnt_r       <= 13'd0;
            y_cnt_r       <= 13'd0;
            armed_r       <= 1'b0;
            line_err_r    <= 1'b0;
            sof_err_r     <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            if (acc_s) begin
                x_cnt_r <= x_nxt_s;
                y_cnt_r <= y_nxt_s;
                armed_r <= armed_s;
            end
            // A new error in the clearing cycle wins over the clear
            line_err_r    <= (line_err_r & ~err_clear) | (acc_s & line_bad_s);
            sof_err_r     <= (sof_err_r & ~err_clear) | (acc_s & sof_bad_s);
            frame_done_r  <= acc_s & frame_end_s;
            frame_count_r <= frame_count_r + {15'd0, acc_s & frame_end_s};
        end
    end

    assign in_ready      = in_ready_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = {ALPHA, head_s[23:0]};
    assign m_axis_tuser  = tvalid_r & head_s[25];
    assign m_axis_tlast  = tvalid_r & head_s[24];
    assign line_err      = line_err_r;
    assign sof_err       = sof_err_r;
    assign frame_done    = frame_done_r;
    assign frame_count   = frame_count_r;
    assign fill_level    = count_r;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer: accepted pixels feed a queue and a geometry model,
// and a monitor checks every output beat, flag and counter against them.
module tb_pixel_stream_packer;
    localparam int DEPTH = 16;
    localparam int FLW   = $clog2(DEPTH) + 1;

    logic           aclk;
    logic           aresetn;
    logic [12:0]    image_width;
    logic [12:0]    image_height;
    logic [7:0]     in_r;
    logic [7:0]     in_g;
    logic [7:0]     in_b;
    logic           in_valid;
    logic           in_sof;
    logic           in_eol;
    logic           in_ready;
    logic [31:0]    m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tuser;
    logic           m_axis_tlast;
    logic           err_clear;
    logic           line_err;
    logic           sof_err;
    logic           frame_done;
    logic [15:0]    frame_count;
    logic [FLW-1:0] fill_level;

    logic rnd_mode;
    logic rnd_tready;
    logic dir_tready;
    assign m_axis_tready = rnd_mode ? rnd_tready : dir_tready;

    pixel_stream_packer #(.DEPTH(DEPTH), .ALPHA(8'hFF)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .image_width(image_width), .image_height(image_height),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol), .in_ready(in_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .err_clear(err_clear), .line_err(line_err), .sof_err(sof_err),
        .frame_done(frame_done), .frame_count(frame_count), .fill_level(fill_level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int out_cnt = 0;
    int acc_cnt = 0;
    int fd_cnt = 0;
    logic [33:0] exp_q[$];

    // reference geometry model state
    int   mx, my, mfc;
    logic marmed, mle, mse, mfd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        rnd_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            rnd_tready = 1'($urandom_range(1, 0));
        end
    end

    // Monitor: compares at each falling edge, then records what the next rising edge will do
    initial begin : monitor
        logic        prev_stall;
        logic        prev_acc_empty;
        logic [33:0] prev_beat;
        logic [33:0] e;
        int          x, y, w, h;
        logic        armed_now, nle, nse;
        prev_stall = 1'b0;
        prev_acc_empty = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                exp_q.delete();
                mx = 0; my = 0; mfc = 0;
                marmed = 1'b0; mle = 1'b0; mse = 1'b0; mfd = 1'b0;
                prev_stall = 1'b0;
                prev_acc_empty = 1'b0;
                check("rst_in_ready", 64'(in_ready), 64'd0);
                check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
                check("rst_tuser_tlast", 64'({m_axis_tuser, m_axis_tlast}), 64'd0);
                check("rst_fill", 64'(fill_level), 64'd0);
                check("rst_frame_count", 64'(frame_count), 64'd0);
                check("rst_flags", 64'({line_err, sof_err, frame_done}), 64'd0);
            end else begin
                check("line_err", 64'(line_err), 64'(mle));
                check("sof_err", 64'(sof_err), 64'(mse));
                check("frame_done", 64'(frame_done), 64'(mfd));
                check("frame_count", 64'(frame_count), 64'(mfc));
                check("fill_level", 64'(fill_level), 64'(exp_q.size()));
                if (frame_done) fd_cnt++;
                if (prev_stall) begin
                    check("tvalid_hold", 64'(m_axis_tvalid), 64'd1);
                    check("data_hold", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(prev_beat));
                end
                if (prev_acc_empty) check("latency", 64'(m_axis_tvalid), 64'd1);
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
                prev_acc_empty = in_valid && in_ready && (fill_level == '0);
                if (m_axis_tvalid && m_axis_tready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        check("spurious_beat_queue", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(e));
                    end
                end
                nle = 1'b0;
                nse = 1'b0;
                mfd = 1'b0;
                if (in_valid && in_ready) begin
                    acc_cnt++;
                    exp_q.push_back({8'hFF, in_r, in_g, in_b, in_sof, in_eol});
                    w = int'(image_width);
                    h = int'(image_height);
                    x = in_sof ? 0 : mx;
                    y = in_sof ? 0 : my;
                    if (in_sof && marmed && (mx != 0 || my != 0)) nse = 1'b1;
                    armed_now = marmed || in_sof;
                    if (armed_now && (in_eol != (x == w - 1))) nle = 1'b1;
                    if (in_eol) begin
                        mx = 0;
                        if (y == h - 1) begin
                            my = 0;
                            if (armed_now) begin
                                mfd = 1'b1;
                                mfc = (mfc + 1) % 65536;
                            end
                        end else begin
                            my = y + 1;
                        end
                    end else begin
                        mx = x + 1;
                        my = y;
                    end
                    marmed = armed_now;
                end
                mle = (mle && !err_clear) || nle;
                mse = (mse && !err_clear) || nse;
            end
        end
    end

    task automatic drive(input logic sof, input logic eol, input int gap_max);
        int   gap;
        int   n;
        logic ok;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge aclk);
            #1;
        end
        in_r = 8'($urandom);
        in_g = 8'($urandom);
        in_b = 8'($urandom);
        in_sof = sof;
        in_eol = eol;
        in_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 2000) begin
            @(negedge aclk);
            ok = in_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
        end
    endtask

    task automatic send_frame(input int w, input int h, input int gap_max);
        image_width = 13'(w);
        image_height = 13'(h);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                drive(xx == 0 && yy == 0, xx == w - 1, gap_max);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 20000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge aclk);
        #1;
        err_clear = 1'b0;
        @(negedge aclk);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int o0, a0, f0, k;
        aresetn = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        image_width = 13'd4; image_height = 13'd2;
        err_clear = 1'b0; rnd_mode = 1'b0; dir_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("ready_low_at_release", 64'(in_ready), 64'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("ready_after_release", 64'(in_ready), 64'd1);
        @(posedge aclk);
        #1;

        // 4x2 frame back-to-back with tready high
        dir_tready = 1'b1;
        o0 = out_cnt; f0 = fd_cnt;
        send_frame(4, 2, 0);
        wait_drain();
        check("t1_beats", 64'(out_cnt - o0), 64'd8);
        check("t1_frame_done_pulses", 64'(fd_cnt - f0), 64'd1);
        check("t1_frame_count", 64'(frame_count), 64'd1);
        check("t1_errors", 64'({line_err, sof_err}), 64'd0);

        // fill to full with tready low, then release
        dir_tready = 1'b0;
        image_width = 13'd16; image_height = 13'd1;
        a0 = acc_cnt; o0 = out_cnt; k = 0;
        in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
        in_sof = 1'b1; in_eol = 1'b0; in_valid = 1'b1;
        repeat (30) begin
            @(negedge aclk);
            if (in_ready) k++;
            @(posedge aclk);
            #1;
            in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            in_sof = ((k % 16) == 0);
            in_eol = ((k % 16) == 15);
        end
        check("t2_accepted", 64'(acc_cnt - a0), 64'd16);
        check("t2_ready_full", 64'(in_ready), 64'd0);
        check("t2_fill_full", 64'(fill_level), 64'd16);
        in_valid = 1'b0;
        dir_tready = 1'b1;
        @(negedge aclk);
        check("t2_ready_before_rd", 64'(in_ready), 64'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("t2_ready_after_rd", 64'(in_ready), 64'd1);
        @(posedge aclk);
        #1;
        wait_drain();
        check("t2_beats", 64'(out_cnt - o0), 64'd16);
        check("t2_frame_count", 64'(frame_count), 64'd2);

        // three random 64x8 frames with random gaps and back-pressure
        rnd_mode = 1'b1;
        o0 = out_cnt;
        repeat (3) send_frame(64, 8, 2);
        rnd_mode = 1'b0;
        wait_drain();
        check("t3_beats", 64'(out_cnt - o0), 64'd1536);
        check("t3_frame_count", 64'(frame_count), 64'd5);
        check("t3_errors", 64'({line_err, sof_err}), 64'd0);

        // early EOL on x=2 of a width-4 line
        image_width = 13'd4; image_height = 13'd2;
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 0);
        wait_drain();
        check("t4_line_err_set", 64'(line_err), 64'd1);
        repeat (3) drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 0);
        wait_drain();
        check("t4_line_err_sticky", 64'(line_err), 64'd1);
        check("t4_frame_count", 64'(frame_count), 64'd6);
        pulse_clear();
        check("t4_line_err_cleared", 64'(line_err), 64'd0);

        // SOF at x=2,y=1 restarts the frame
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 0);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        wait_drain();
        check("t5_sof_err", 64'(sof_err), 64'd1);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 0);
        repeat (3) drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 0);
        wait_drain();
        check("t5_no_line_err", 64'(line_err), 64'd0);
        check("t5_frame_count", 64'(frame_count), 64'd7);
        pulse_clear();
        check("t5_sof_err_cleared", 64'(sof_err), 64'd0);

        // reset with 10 beats buffered
        dir_tready = 1'b0;
        image_width = 13'd64; image_height = 13'd8;
        drive(1'b1, 1'b0, 0);
        repeat (9) drive(1'b0, 1'b0, 0);
        check("t6_fill_before_reset", 64'(fill_level), 64'd10);
        aresetn = 1'b0;
        #1;
        check("t6_tvalid_immediate", 64'(m_axis_tvalid), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("t6_fill_after", 64'(fill_level), 64'd0);
        check("t6_count_after", 64'(frame_count), 64'd0);
        check("t6_ready_low", 64'(in_ready), 64'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("t6_ready_high", 64'(in_ready), 64'd1);
        @(posedge aclk);
        #1;
        dir_tready = 1'b1;
        o0 = out_cnt;
        send_frame(4, 1, 0);
        wait_drain();
        check("t6_beats", 64'(out_cnt - o0), 64'd4);
        check("t6_frame_count", 64'(frame_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
